uart_absorber: RTL and testbench

UART-to-AXI-stream receiver, the inbound counterpart of the byte emitter used by the corescore top levels. It oversamples an asynchronous 8N1 serial line and reassembles bytes. Bytes are buffered in a small FIFO and presented as an AXI-stream byte source (tdata/tlast/tvalid/tready). A host can then drive an on-chip stream consumer over the board's UART.

---
 rtl/uart_absorber.sv | 193 +++++++++++++++++++
 tb/tb_uart_absorber.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_absorber.sv
// UART 8N1 receiver with a small FIFO, presented as an AXI-stream byte source.
// Define UART_ABSORBER_PARITY_EN to receive 8E1 frames with parity checking.
module uart_absorber #(
    parameter int          CLK_FREQ_HZ = 16000000,
    parameter int          BAUD_RATE   = 57600,
    parameter int          DEPTH       = 4,
    parameter logic [7:0]  LAST_CHAR   = 8'h0A
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_uart_rx,
    output logic [7:0] o_tdata,
    output logic       o_tlast,
    output logic       o_tvalid,
    input  logic       i_tready,
    output logic       o_frame_err,
    output logic       o_overrun,
    output logic       o_parity_err
);

    localparam int CPB  = CLK_FREQ_HZ / BAUD_RATE;
    localparam int HALF = CPB / 2;
    localparam int CW   = $clog2(CPB + 1);
    localparam int AW   = $clog2(DEPTH);

`ifdef UART_ABSORBER_PARITY_EN
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK
    } state_t;
`else
    typedef enum logic [2:0] {
        S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
    } state_t;
`endif

    state_t        state, state_n;
    logic          rx_s1, rx_s2;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_idx, bit_n;
    logic [7:0]    shift, shift_n;
    logic          push_q, push_n;
    logic          ferr_q, ferr_n;
`ifdef UART_ABSORBER_PARITY_EN
    logic          par_bad, par_bad_n;
    logic          perr_q, perr_n;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rx_s1   <= 1'b1;
            rx_s2   <= 1'b1;
            state   <= S_IDLE;
            cnt     <= '0;
            bit_idx <= '0;
            shift   <= '0;
            push_q  <= 1'b0;
            ferr_q  <= 1'b0;
`ifdef UART_ABSORBER_PARITY_EN
            par_bad <= 1'b0;
            perr_q  <= 1'b0;
`endif
        end else begin
            rx_s1   <= i_uart_rx;
            rx_s2   <= rx_s1;
            state   <= state_n;
            cnt     <= cnt_n;
            bit_idx <= bit_n;
            shift   <= shift_n;
            push_q  <= push_n;
            ferr_q  <= ferr_n;
`ifdef UART_ABSORBER_PARITY_EN
            par_bad <= par_bad_n;
            perr_q  <= perr_n;
`endif
        end
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        bit_n   = bit_idx;
        shift_n = shift;
        push_n  = 1'b0;
        ferr_n  = 1'b0;
`ifdef UART_ABSORBER_PARITY_EN
        par_bad_n = par_bad;
        perr_n    = 1'b0;
`endif
        unique case (state)
            S_IDLE: begin
                if (!rx_s2) begin
                    cnt_n   = CW'(HALF - 1);
                    state_n = S_START;
                end
            end
            S_START: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s2) begin
                    state_n = S_IDLE;
                end else begin
                    cnt_n   = CW'(CPB - 1);
                    bit_n   = 3'd0;
                    state_n = S_DATA;
                end
            end
            S_DATA: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    shift_n = {rx_s2, shift[7:1]};
                    cnt_n   = CW'(CPB - 1);
                    bit_n   = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_ABSORBER_PARITY_EN
                        state_n = S_PARITY;
`else
                        state_n = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_ABSORBER_PARITY_EN
            S_PARITY: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else begin
                    par_bad_n = ^{shift, rx_s2};
                    cnt_n     = CW'(CPB - 1);
                    state_n   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (cnt != '0) begin
                    cnt_n = cnt - 1'b1;
                end else if (rx_s2) begin
                    // Leave mid-stop-bit so a back-to-back start edge is seen
                    state_n = S_IDLE;
`ifdef UART_ABSORBER_PARITY_EN
                    perr_n  = par_bad;
                    push_n  = !par_bad;
`else
                    push_n  = 1'b1;
`endif
                end else begin
                    ferr_n  = 1'b1;
                    state_n = S_BREAK;
                end
            end
            S_BREAK: begin
                if (rx_s2) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase
    end

    logic [AW:0] wptr, rptr;
    logic [8:0]  mem [DEPTH];
    logic        empty, full, pop, push;

    assign empty = (wptr == rptr);
    assign full  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop   = !empty && i_tready;
    assign push  = push_q && (!full || pop);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wptr <= '0;
            rptr <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr[AW-1:0]] <= {shift == LAST_CHAR, shift};
                wptr <= wptr + 1'b1;
            end
            if (pop) rptr <= rptr + 1'b1;
        end
    end

    assign o_tvalid    = !empty;
    assign o_tdata     = empty ? 8'h00 : mem[rptr[AW-1:0]][7:0];
    assign o_tlast     = empty ? 1'b0 : mem[rptr[AW-1:0]][8];
    assign o_overrun   = push_q && full && !pop;
    assign o_frame_err = ferr_q;
`ifdef UART_ABSORBER_PARITY_EN
    assign o_parity_err = perr_q;
`else
    assign o_parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_absorber.sv
// Testbench for uart_absorber: table vectors, corner sequences, random frames.
module tb_uart_absorber;

    localparam int CPB = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx = 1'b1;
    logic       tready = 1'b0;
    logic [7:0] tdata;
    logic       tlast, tvalid, ferr, ovr, perr;

    always #5 clk = ~clk;

    uart_absorber #(
        .CLK_FREQ_HZ(800),
        .BAUD_RATE(100),
        .DEPTH(4),
        .LAST_CHAR(8'h0A)
    ) dut (
        .i_clk(clk),
        .i_rst(rst),
        .i_uart_rx(rx),
        .o_tdata(tdata),
        .o_tlast(tlast),
        .o_tvalid(tvalid),
        .i_tready(tready),
        .o_frame_err(ferr),
        .o_overrun(ovr),
        .o_parity_err(perr)
    );

    int vectors = 0;
    int miscompares = 0;

    logic [8:0] got_q[$];
    int ferr_cnt, ovr_cnt, perr_cnt, multi_cnt, valid_cycles;
    logic rand_en = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            if (tvalid && tready) got_q.push_back({tlast, tdata});
            if (tvalid) valid_cycles++;
            ferr_cnt += int'(ferr);
            ovr_cnt  += int'(ovr);
            perr_cnt += int'(perr);
            if (int'(ferr) + int'(ovr) + int'(perr) > 1) multi_cnt++;
        end
    end

    always @(posedge clk) begin
        if (rand_en) begin
            #1;
            tready = 1'($urandom % 2);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bit(input logic v);
        rx = v;
        step(CPB);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(stop);
    endtask

    task automatic clear_mon();
        got_q.delete();
        ferr_cnt = 0;
        ovr_cnt = 0;
        valid_cycles = 0;
    endtask

    typedef struct {
        logic [7:0] data;
        logic       stop;
        int         exp_beats;
        logic       exp_last;
        int         exp_ferr;
    } vec_t;

    vec_t tbl[7];
    logic [8:0] exp_q[$];
    int exp_ferr;
    logic [7:0] d;
    logic good;
    logic [7:0] held;
    int unstable;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 1, 1'b0, 0};
        tbl[1] = '{8'h0A, 1'b1, 1, 1'b1, 0};
        tbl[2] = '{8'hA5, 1'b0, 0, 1'b0, 1};
        tbl[3] = '{8'h00, 1'b1, 1, 1'b0, 0};
        tbl[4] = '{8'hFF, 1'b1, 1, 1'b0, 0};
        tbl[5] = '{8'h80, 1'b1, 1, 1'b0, 0};
        tbl[6] = '{8'h0B, 1'b1, 1, 1'b0, 0};
        clear_mon();
        perr_cnt = 0;
        multi_cnt = 0;

        step(3);
        @(negedge clk);
        chk("reset_tvalid", int'(tvalid), 0);
        chk("reset_tdata", int'(tdata), 0);
        chk("reset_tlast", int'(tlast), 0);
        chk("reset_errs", int'({ferr, ovr, perr}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step(5);

        tready = 1'b1;
        for (int v = 0; v < 7; v++) begin
            clear_mon();
            send_frame(tbl[v].data, tbl[v].stop);
            if (!tbl[v].stop) begin
                repeat (3) send_bit(1'b0);
                rx = 1'b1;
            end
            step(3 * CPB);
            chk($sformatf("tbl%0d_beats", v), got_q.size(), tbl[v].exp_beats);
            chk($sformatf("tbl%0d_vcyc", v), valid_cycles, tbl[v].exp_beats);
            chk($sformatf("tbl%0d_ferr", v), ferr_cnt, tbl[v].exp_ferr);
            chk($sformatf("tbl%0d_ovr", v), ovr_cnt, 0);
            if (got_q.size() > 0 && tbl[v].exp_beats > 0)
                chk($sformatf("tbl%0d_beat", v), int'(got_q[0]),
                    int'({tbl[v].exp_last, tbl[v].data}));
        end

        clear_mon();
        send_frame(8'h0A, 1'b1);
        send_frame(8'h41, 1'b1);
        step(3 * CPB);
        chk("b2b_beats", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b_first", int'(got_q[0]), int'({1'b1, 8'h0A}));
            chk("b2b_second", int'(got_q[1]), int'({1'b0, 8'h41}));
        end

        clear_mon();
        rx = 1'b0;
        step(2);
        rx = 1'b1;
        step(3 * CPB);
        chk("false_start_beats", got_q.size(), 0);
        chk("false_start_ferr", ferr_cnt, 0);
        send_frame(8'h5A, 1'b1);
        step(3 * CPB);
        chk("after_false_start", got_q.size() > 0 ? int'(got_q[0]) : -1,
            int'({1'b0, 8'h5A}));

        clear_mon();
        send_frame(8'hA5, 1'b0);
        repeat (3) send_bit(1'b0);
        rx = 1'b1;
        step(CPB);
        send_frame(8'h3C, 1'b1);
        step(3 * CPB);
        chk("break_ferr", ferr_cnt, 1);
        chk("break_beats", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("break_beat", int'(got_q[0]), int'({1'b0, 8'h3C}));

        clear_mon();
        tready = 1'b0;
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1);
        step(3 * CPB);
        @(negedge clk);
        chk("full_tvalid", int'(tvalid), 1);
        chk("full_tdata", int'(tdata), 1);
        chk("full_ovr", ovr_cnt, 1);
        held = tdata;
        unstable = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (tdata !== held || !tvalid) unstable++;
        end
        chk("stall_stable", unstable, 0);
        step(1);
        tready = 1'b1;
        step(10);
        chk("drain_beats", got_q.size(), 4);
        for (int i = 0; i < 4 && i < got_q.size(); i++)
            chk($sformatf("drain%0d", i), int'(got_q[i]), i + 1);
        @(negedge clk);
        chk("drain_tvalid", int'(tvalid), 0);
        chk("drain_tdata", int'(tdata), 0);
        chk("drain_tlast", int'(tlast), 0);

        tready = 1'b0;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        step(2 * CPB);
        d = 8'h99;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(d[i]);
        rx = d[4];
        step(4);
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_tvalid", int'(tvalid), 0);
        chk("rst_tdata", int'(tdata), 0);
        step(1);
        rx = 1'b1;
        step(2 * CPB);
        clear_mon();
        tready = 1'b1;
        send_frame(8'h7E, 1'b1);
        step(3 * CPB);
        chk("post_rst_beats", got_q.size(), 1);
        if (got_q.size() > 0)
            chk("post_rst_beat", int'(got_q[0]), int'({1'b0, 8'h7E}));

        clear_mon();
        exp_q.delete();
        exp_ferr = 0;
        rand_en = 1'b1;
        for (int n = 0; n < 25; n++) begin
            d = 8'($urandom);
            if ($urandom % 5 == 0) d = 8'h0A;
            good = ($urandom % 8) != 0;
            send_frame(d, good);
            if (good) begin
                exp_q.push_back({d == 8'h0A, d});
            end else begin
                exp_ferr++;
                send_bit(1'b0);
                rx = 1'b1;
                step(CPB);
            end
            step(int'($urandom % 20));
        end
        rand_en = 1'b0;
        step(1);
        tready = 1'b1;
        step(3 * CPB);
        chk("rand_beats", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk($sformatf("rand%0d", i), int'(got_q[i]), int'(exp_q[i]));
        chk("rand_ferr", ferr_cnt, exp_ferr);
        chk("rand_ovr", ovr_cnt, 0);

        chk("perr_never", perr_cnt, 0);
        chk("pulse_exclusive", multi_cnt, 0);

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
